// File: rtl/byte_record_fifo_pkg.sv
// rtl/byte_record_fifo_pkg.sv - shared types and width helper for the byte record FIFO
package byte_record_fifo_pkg;

  typedef logic [7:0] byte_t;

  function automatic int cnt_width(input int slots);
    return $clog2(slots + 1);
  endfunction

endpackage

// File: rtl/record_assembler.sv
// rtl/record_assembler.sv - gathers bytes into one record and emits it on the final byte
module record_assembler
  import byte_record_fifo_pkg::*;
#(
  parameter int RECORD_BYTES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  byte_t                     in_byte_i,
  input  logic                      accept_i,
  input  logic                      abort_i,
  input  logic                      flush_i,
  output logic                      last_lane_o,
  output logic                      rec_push_o,
  output logic [RECORD_BYTES*8-1:0] rec_data_o
);

  localparam int IW = (RECORD_BYTES > 1) ? $clog2(RECORD_BYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(RECORD_BYTES - 1);

  logic [IW-1:0]             idx_q, idx_d;
  logic [RECORD_BYTES*8-1:0] asm_q, asm_d;
  logic                      take;

  assign last_lane_o = (idx_q == LAST_IDX);
  assign take        = accept_i && !abort_i && !flush_i;
  assign rec_push_o  = take && last_lane_o;

  // The record being pushed includes the byte arriving this cycle.
  always_comb begin
    rec_data_o = asm_q;
    rec_data_o[idx_q*8 +: 8] = in_byte_i;
  end

  always_comb begin
    idx_d = idx_q;
    asm_d = asm_q;
    if (flush_i || abort_i) begin
      idx_d = '0;
    end else if (take) begin
      asm_d = rec_data_o;
      idx_d = last_lane_o ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q <= '0;
      asm_q <= '0;
    end else begin
      idx_q <= idx_d;
      asm_q <= asm_d;
    end
  end

endmodule

// File: rtl/byte_record_fifo.sv
// rtl/byte_record_fifo.sv - byte-in, record-out FIFO with occupancy, almost-full, flush and overflow
module byte_record_fifo
  import byte_record_fifo_pkg::*;
#(
  parameter int RECORD_BYTES = 16,
  parameter int SLOTS        = 32,
  parameter int ALMOST_FULL  = SLOTS - 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  byte_t                          in_byte,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_abort,
  input  logic                           flush,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [RECORD_BYTES*8-1:0]      out_record,
  output logic [cnt_width(SLOTS)-1:0]    count,
  output logic                           almost_full,
  output logic                           overflow
);

  localparam int CW = cnt_width(SLOTS);
  localparam int PW = $clog2(SLOTS);

  logic [RECORD_BYTES*8-1:0] mem_q [SLOTS];
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]             count_q, count_d;
  logic                      af_q, af_d, ovf_q, ovf_d;
  logic                      last_lane, rec_push, accept, pop;
  logic [RECORD_BYTES*8-1:0] rec_data;

  record_assembler #(.RECORD_BYTES(RECORD_BYTES)) u_asm (
    .clk        (clk),
    .rst        (rst),
    .in_byte_i  (in_byte),
    .accept_i   (accept),
    .abort_i    (in_abort),
    .flush_i    (flush),
    .last_lane_o(last_lane),
    .rec_push_o (rec_push),
    .rec_data_o (rec_data)
  );

  // Only the final byte of a record needs a free slot; earlier bytes always fit.
  assign in_ready    = !(last_lane && (count_q == CW'(SLOTS)));
  assign accept      = in_valid && in_ready;
  assign out_valid   = (count_q != '0);
  assign pop         = out_valid && out_ready && !flush;
  assign out_record  = mem_q[rd_ptr_q];
  assign count       = count_q;
  assign almost_full = af_q;
  assign overflow    = ovf_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (in_valid && !in_ready);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (rec_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)      rd_ptr_d = rd_ptr_q + 1'b1;
      if (rec_push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !rec_push) count_d = count_q - 1'b1;
    end
    af_d = (count_d >= CW'(ALMOST_FULL));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      af_q     <= (ALMOST_FULL == 0);
      ovf_q    <= 1'b0;
      for (int i = 0; i < SLOTS; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
      if (rec_push) mem_q[wr_ptr_q] <= rec_data;
    end
  end

endmodule
